framebuffer_scanout: RTL
========================

# framebuffer_scanout

Read side of the 160x120 frame buffer. The drawing blocks write pixel addresses and colours into the frame buffer. This block reads the buffer back continuously and drives a 640x480@60 Hz VGA raster, replicating each stored pixel 4x4. It also emits a one-cycle frame-start pulse at the start of vertical blanking so the drawing side can begin its next pass.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths (line = 800)
- V_VISIBLE, 480, visible lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths (frame = 525)
- FB_WIDTH, 160, frame buffer columns; FB_HEIGHT, 120, rows

Ports:
- clk  in  1  50 MHz system clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- fbAddress  out  15  frame buffer read address
- fbColour  in  24  frame buffer read data, {R,G,B}; valid one clk after fbAddress
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_HS, VGA_VS  out  1  sync, active-low
- VGA_BLANK_N  out  1  low outside the visible region
- VGA_SYNC_N  out  1  tied 0
- VGA_CLK  out  1  pixel clock; equals the pixEn phase
- frameStart  out  1  one-clk pulse at the start of vertical blank

## Operation
- pixEn toggles every clk, giving a 25 MHz pixel rate. All raster state advances only on clocks where pixEn=1.
- hCount runs 0..799 and wraps to 0. At the wrap, vCount increments over 0..524 and wraps to 0.
- Visible region: hCount<640 and vCount<480.
- HS is low for hCount in 656..751.
- VS is low for vCount in 490..491.
- Address formula: fbAddress = (vCount[8:2] << 7) + (vCount[8:2] << 5) + hCount[9:2].
  - Width is 15 bits; the maximum value is 119*160+159 = 19199.
  - Outside the visible region, fbAddress holds its last value; the colour is forced to 0 regardless of its value.
- Pipeline: counters → registered address → RAM data → registered output.
  - HS, VS and BLANK are delayed by the same number of stages, so the colour and the syncs for one raster position leave the block on the same clk.
- frameStart pulses high for exactly one clk, on the pixEn clk where vCount becomes 480 (hCount=0). This gives one pulse per frame.
- No handshake on the read port; the RAM is read every pixel period unconditionally.

## Timing
- Reset values: hCount=0, vCount=0, pixEn=0, fbAddress=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frameStart=0, VGA_CLK=0.
- Latency from a counter value to the aligned pins is 2 pixel periods (4 clk), fixed.
- Line period is 1600 clk; frame period is 840000 clk.
- HS low pulse is 192 clk; VS low pulse is 3200 clk.
- Reset mid-frame: all outputs return to their reset values asynchronously. Scanout resumes from hCount=0, vCount=0 on the first clk after release.
  - No frameStart is produced until vCount next reaches 480.
- Column boundary: for hCount 636..639 the address column is 159. At hCount=640, BLANK_N falls (after the pipeline delay) and the colour is 0.
- Row boundary: vCount 476..479 maps to row 119. vCount 480 is blank.
- The ram read latency is exactly 1 clk. Any change to it requires retuning the delay stages.

## Structure
- Shared package (DefineMacros.vh):
  - H/V timing constants
  - FB_WIDTH / FB_HEIGHT
  - FB_ADDR_W = 15
  - COLOUR_W = 24
- Sub-module scanout_timing_gen: pixEn, hCount/vCount, raw hsync/vsync/visible, frameStart.
- Top level: address computation, delay-stage registers, colour gating.

## Test plan
- Reset: hold resetn=0 and check every output against its reset value. Release, and check VGA_HS first falls 1312 clk after the first pixEn plus the 4-clk latency.
- Line and frame timing: measure 1600 clk between HS falls, 840000 clk between VS falls, and 840000 clk between frameStart pulses. Each pulse is exactly 1 clk wide.
- Addressing: at hCount=0,vCount=0 → 0; hCount=7,vCount=5 → 161; hCount=639,vCount=479 → 19199. Check every address ≤ 19199.
- Alignment: a RAM model returns colour = {9'b0, address}. Verify VGA_R/G/B equals the expected address for each visible pixel, and is 0 whenever VGA_BLANK_N=0.
- Replication: each address appears for exactly 8 consecutive clk within a line, and on 4 consecutive lines.
- Mid-frame reset: assert resetn=0 at vCount=200 and check outputs return to reset values immediately. Release, and check the next frameStart arrives 480 lines (768000 clk + latency) later.

Source files
------------

// File: rtl/framebuffer_scanout_pkg.sv
// Raster timing defaults and control types shared by the VGA scanout path.
package framebuffer_scanout_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_FB_WIDTH  = 160;
    localparam int DEF_FB_HEIGHT = 120;

    localparam int FB_ADDR_W = 15;
    localparam int COLOUR_W  = 24;

    // Per-pixel control travelling alongside the colour through the pipeline.
    typedef struct packed {
        logic hSyncN;
        logic vSyncN;
        logic visible;
    } rasterCtl_t;

    localparam rasterCtl_t CTL_RESET = '{hSyncN: 1'b1, vSyncN: 1'b1, visible: 1'b0};

endpackage

// File: rtl/framebuffer_scanout_timing_gen.sv
// Raster counters at half the system clock, raw sync/visible decode and the
// frame-start pulse at the first line of vertical blanking.
module scanout_timing_gen
    import framebuffer_scanout_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int HW        = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
    parameter int VW        = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic          pixEn,
    output logic [HW-1:0] hCount,
    output logic [VW-1:0] vCount,
    output rasterCtl_t    rawCtl,
    output logic          frameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS    = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SE    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_VIS_L = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] V_SS    = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SE    = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic hLast;
    logic vLast;

    assign hLast = (hCount == H_LAST);
    assign vLast = (vCount == V_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixEn      <= 1'b0;
            hCount     <= '0;
            vCount     <= '0;
            frameStart <= 1'b0;
        end else begin
            pixEn      <= ~pixEn;
            // Fires on the same edge that moves the counters onto the first blank line.
            frameStart <= pixEn && hLast && (vCount == V_VIS_L);
            if (pixEn) begin
                hCount <= hLast ? '0 : hCount + 1'b1;
                if (hLast)
                    vCount <= vLast ? '0 : vCount + 1'b1;
            end
        end
    end

    assign rawCtl.visible = (hCount < H_VIS_C) && (vCount < V_VIS_C);
    assign rawCtl.hSyncN  = !((hCount >= H_SS) && (hCount < H_SE));
    assign rawCtl.vSyncN  = !((vCount >= V_SS) && (vCount < V_SE));

endmodule

// File: rtl/framebuffer_scanout.sv
// Frame buffer read side: 160x120 buffer scanned out as a 640x480 raster with
// 4x4 pixel replication; colour and syncs leave aligned two pixel periods later.
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int FB_WIDTH  = DEF_FB_WIDTH,
    parameter int FB_HEIGHT = DEF_FB_HEIGHT
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [FB_ADDR_W-1:0] fbAddress,
    input  logic [COLOUR_W-1:0]  fbColour,
    output logic [7:0]           VGA_R,
    output logic [7:0]           VGA_G,
    output logic [7:0]           VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N,
    output logic                 VGA_SYNC_N,
    output logic                 VGA_CLK,
    output logic                 frameStart
);

    localparam int HW    = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam int VW    = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam int COL_W = $clog2(FB_WIDTH);
    localparam int ROW_W = $clog2(FB_HEIGHT);

    logic          pixEn;
    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;
    rasterCtl_t    rawCtl;
    rasterCtl_t    ctlD;

    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [FB_ADDR_W-1:0] addrNext;

    scanout_timing_gen #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .HW(HW), .VW(VW)
    ) uTiming (
        .clk       (clk),
        .resetn    (resetn),
        .pixEn     (pixEn),
        .hCount    (hCount),
        .vCount    (vCount),
        .rawCtl    (rawCtl),
        .frameStart(frameStart)
    );

    assign col = COL_W'(hCount >> 2);
    assign row = ROW_W'(vCount >> 2);

    // row*160 as two shifts; the buffer pitch is fixed at 160 words.
    assign addrNext = (FB_ADDR_W'(row) << 7) + (FB_ADDR_W'(row) << 5) + FB_ADDR_W'(col);

    // Stage 1: address to the RAM, control held alongside it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fbAddress <= '0;
            ctlD      <= CTL_RESET;
        end else if (pixEn) begin
            ctlD <= rawCtl;
            if (rawCtl.visible)
                fbAddress <= addrNext;
        end
    end

    // Stage 2: RAM data has landed one clk after the address; register to the pins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
            VGA_HS                <= 1'b1;
            VGA_VS                <= 1'b1;
            VGA_BLANK_N           <= 1'b0;
        end else if (pixEn) begin
            {VGA_R, VGA_G, VGA_B} <= ctlD.visible ? fbColour : '0;
            VGA_HS                <= ctlD.hSyncN;
            VGA_VS                <= ctlD.vSyncN;
            VGA_BLANK_N           <= ctlD.visible;
        end
    end

    assign VGA_CLK    = pixEn;
    assign VGA_SYNC_N = 1'b0;

endmodule
